// File: rtl/alu_div_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_div_sequencer_pkg
// Shared definitions for the DIVU/REMU sequencer that drives an external
// ALU16: ALU operation encodings, the sequencer state encoding and the index
// of the last restoring-division iteration.
// ---------------------------------------------------------------------------
package alu_div_sequencer_pkg;

  // ALU16 Op field encodings
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Counter value of the final shift/subtract iteration (16 iterations)
  localparam int ITER_LAST = 15;

endpackage

// File: rtl/alu_div_sequencer.sv
// ---------------------------------------------------------------------------
// alu_div_sequencer
// Multi-cycle unsigned 16-bit restoring divider that borrows a shared ALU16
// for its compare/subtract work instead of owning a subtractor.
//
// Ports:
//   Clock, Reset            rising-edge clock, asynchronous active-low reset
//   Start                   request pulse, only honoured in IDLE
//   Dividend, Divisor       operands, captured when Start is accepted
//   Busy                    high in CHECK and RUN
//   Done                    one-cycle completion pulse (FINISH)
//   Quotient, Remainder     results, held until the next completion
//   DivByZero               set with a zero divisor, held like the results
//   AluA, AluB, AluAInvert,
//   AluBNegate, AluOp       operand/control drive into ALU16
//   AluResult, AluZero,
//   AluCarryOut             ALU16 results
// ---------------------------------------------------------------------------
module alu_div_sequencer
  import alu_div_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] Dividend,
  input  logic [DATA_W-1:0] Divisor,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Quotient,
  output logic [DATA_W-1:0] Remainder,
  output logic              DivByZero,
  output logic [DATA_W-1:0] AluA,
  output logic [DATA_W-1:0] AluB,
  output logic              AluAInvert,
  output logic              AluBNegate,
  output logic [1:0]        AluOp,
  input  logic [DATA_W-1:0] AluResult,
  input  logic              AluZero,
  input  logic              AluCarryOut
);

  state_t            state, state_next;
  logic [DATA_W-1:0] q, d, r;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] trial, q_next, r_next;
  logic              top, ge, last_iter;

  // One restoring step. The shifted partial remainder is 17 bits wide; its
  // top bit is r[DATA_W-1], so r itself only needs DATA_W bits. When that top
  // bit is set the trial value certainly exceeds D and the 16-bit ALU
  // difference is exact because the true difference fits in 16 bits.
  always_comb begin
    trial     = {r[DATA_W-2:0], q[DATA_W-1]};
    top       = r[DATA_W-1];
    ge        = top | AluCarryOut;
    q_next    = {q[DATA_W-2:0], ge};
    r_next    = ge ? AluResult : trial;
    last_iter = (cnt == CNT_W'(ITER_LAST));
  end

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = CHECK;
      CHECK:   state_next = AluZero ? FINISH : RUN;
      RUN:     if (last_iter) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: handshake flags and ALU drive decoded from state.
  // CHECK ORs the divisor with zero so AluZero flags a zero divisor; RUN
  // computes trial - D as trial + ~D + 1 so CarryOut means trial >= D.
  always_comb begin
    Busy       = 1'b0;
    Done       = 1'b0;
    AluA       = '0;
    AluB       = '0;
    AluAInvert = 1'b0;
    AluBNegate = 1'b0;
    AluOp      = OP_AND;
    case (state)
      CHECK: begin
        Busy  = 1'b1;
        AluA  = d;
        AluOp = OP_OR;
      end
      RUN: begin
        Busy       = 1'b1;
        AluA       = trial;
        AluB       = d;
        AluBNegate = 1'b1;
        AluOp      = OP_ADD;
      end
      FINISH:  Done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers. Results are only written on the way into FINISH so
  // they stay stable for the whole of an operation.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      q         <= '0;
      d         <= '0;
      r         <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            q   <= Dividend;
            d   <= Divisor;
            r   <= '0;
            cnt <= '0;
          end
        end
        CHECK: begin
          if (AluZero) begin
            Quotient  <= '1;
            Remainder <= q;
            DivByZero <= 1'b1;
          end
        end
        RUN: begin
          q   <= q_next;
          r   <= r_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            Quotient  <= q_next;
            Remainder <= r_next;
            DivByZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_div_sequencer
// Drives alu_div_sequencer together with a behavioural ALU16 and compares
// results, latency and handshake behaviour with plain integer division.
// ---------------------------------------------------------------------------
module tb_alu_div_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] Dividend = '0;
  logic [15:0] Divisor = '0;
  logic        Busy, Done, DivByZero;
  logic [15:0] Quotient, Remainder;
  logic [15:0] AluA, AluB, AluResult;
  logic        AluAInvert, AluBNegate, AluZero, AluCarryOut;
  logic [1:0]  AluOp;

  int testCount = 0;
  int failCount = 0;

  logic [15:0] heldQ = '0;
  logic [15:0] heldR = '0;
  logic        heldZ = 1'b0;

  alu_div_sequencer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Dividend   (Dividend),
    .Divisor    (Divisor),
    .Busy       (Busy),
    .Done       (Done),
    .Quotient   (Quotient),
    .Remainder  (Remainder),
    .DivByZero  (DivByZero),
    .AluA       (AluA),
    .AluB       (AluB),
    .AluAInvert (AluAInvert),
    .AluBNegate (AluBNegate),
    .AluOp      (AluOp),
    .AluResult  (AluResult),
    .AluZero    (AluZero),
    .AluCarryOut(AluCarryOut)
  );

  always #5 Clock = ~Clock;

  // ALU16: optional inversion of A, B negation via ~B with carry-in,
  // AND/OR/ADD/SLT selected by Op.
  logic [15:0] aEff, bEff;
  logic [16:0] sum;
  logic        slt;
  always_comb begin
    aEff = AluAInvert ? ~AluA : AluA;
    bEff = AluBNegate ? ~AluB : AluB;
    sum  = {1'b0, aEff} + {1'b0, bEff} + {16'b0, AluBNegate};
    slt  = sum[15] ^ ((aEff[15] == bEff[15]) && (sum[15] != aEff[15]));
    case (AluOp)
      2'b00:   AluResult = aEff & bEff;
      2'b01:   AluResult = aEff | bEff;
      2'b10:   AluResult = sum[15:0];
      default: AluResult = {15'b0, slt};
    endcase
    AluZero     = (AluResult == 16'h0000);
    AluCarryOut = sum[16];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands with Start, step past the accepting edge, then scramble
  // the operand inputs to show they are not sampled again.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    @(posedge Clock); #1;
    Start    = 1'b0;
    Dividend = 16'($urandom);
    Divisor  = 16'($urandom);
  endtask

  // Full divide with checks; pulseAt > 0 raises Start again in that cycle
  // after acceptance, which must be ignored.
  task automatic runDivide(input logic [15:0] a, input logic [15:0] b,
                           input int pulseAt);
    logic [15:0] expQ, expR;
    logic        expZ;
    int          expLat, cyc, busyCnt, extraDone, extraBusy;
    expZ   = (b == 16'h0000);
    expQ   = expZ ? 16'hFFFF : a / b;
    expR   = expZ ? a : a % b;
    expLat = expZ ? 2 : 18;

    applyStimulus(a, b);
    checkOutput("check_busy", 32'(Busy), 32'd1);
    checkOutput("check_aluop", 32'(AluOp), 32'd1);
    checkOutput("check_alua", 32'(AluA), 32'(b));
    checkOutput("held_quotient", 32'(Quotient), 32'(heldQ));
    checkOutput("held_remainder", 32'(Remainder), 32'(heldR));
    checkOutput("held_divbyzero", 32'(DivByZero), 32'(heldZ));

    cyc     = 1;
    busyCnt = 0;
    while (!Done && cyc < 40) begin
      if (Busy) busyCnt++;
      if (cyc == pulseAt) begin
        Dividend = 16'h0003;
        Divisor  = 16'h0001;
        Start    = 1'b1;
      end
      @(posedge Clock); #1;
      Start = 1'b0;
      cyc++;
    end

    checkOutput("latency", 32'(cyc), 32'(expLat));
    checkOutput("busy_cycles", 32'(busyCnt), 32'(expLat - 1));
    checkOutput("done", 32'(Done), 32'd1);
    checkOutput("done_busy", 32'(Busy), 32'd0);
    checkOutput("quotient", 32'(Quotient), 32'(expQ));
    checkOutput("remainder", 32'(Remainder), 32'(expR));
    checkOutput("divbyzero", 32'(DivByZero), 32'(expZ));
    heldQ = expQ;
    heldR = expR;
    heldZ = expZ;

    extraDone = 0;
    extraBusy = 0;
    repeat (3) begin
      @(posedge Clock); #1;
      if (Done) extraDone++;
      if (Busy) extraBusy++;
    end
    checkOutput("extra_done", 32'(extraDone), 32'd0);
    checkOutput("extra_busy", 32'(extraBusy), 32'd0);
    checkOutput("post_quotient", 32'(Quotient), 32'(expQ));
    checkOutput("post_remainder", 32'(Remainder), 32'(expR));
  endtask

  initial begin
    logic [15:0] ra, rb;

    // Reset state
    #1;
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_done", 32'(Done), 32'd0);
    checkOutput("reset_quotient", 32'(Quotient), 32'd0);
    checkOutput("reset_aluop", 32'(AluOp), 32'd0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    checkOutput("idle_alua", 32'(AluA), 32'd0);
    checkOutput("idle_alubnegate", 32'(AluBNegate), 32'd0);

    // Directed cases
    runDivide(16'd100, 16'd7, 0);
    runDivide(16'hFFFF, 16'h8000, 0);
    runDivide(16'h8000, 16'h8001, 0);
    runDivide(16'd5, 16'd0, 0);
    runDivide(16'hFFFF, 16'd1, 0);
    runDivide(16'hFFFF, 16'd1, 6);

    // Reset during RUN with counter at 8 (cycle 10 after acceptance)
    applyStimulus(16'h1234, 16'h0056);
    repeat (9) begin
      @(posedge Clock); #1;
    end
    checkOutput("prereset_busy", 32'(Busy), 32'd1);
    Reset = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(Busy), 32'd0);
    checkOutput("abort_done", 32'(Done), 32'd0);
    checkOutput("abort_quotient", 32'(Quotient), 32'd0);
    checkOutput("abort_remainder", 32'(Remainder), 32'd0);
    checkOutput("abort_aluop", 32'(AluOp), 32'd0);
    heldQ = '0;
    heldR = '0;
    heldZ = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    runDivide(16'd9, 16'd3, 0);

    // Randomized operands, including zero and small divisors
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'h0000;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = 16'h8000 | 16'($urandom);
        default: rb = 16'($urandom);
      endcase
      runDivide(ra, rb, (i % 4 == 1) ? 8 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
